// File: rtl/lsu_mem_port.sv
// Purpose: load/store initiator between the core memory stage and a single-port byte-strobed data RAM.
// Latency: response valid 2 cycles after request accept; one request per 3 cycles at best.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   req_*              core request (valid/ready): we, size, unsigned, byte address, store data
//   resp_*             core response (valid/ready): extended load data and error flag
//   mem_*              RAM side: write enable, byte strobes, word address, write data, comb. read data
module lsu_mem_port #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [3:0]            mem_wr_strobe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Fields of the accepted request needed after the accept cycle.
    typedef struct packed {
        logic       we;
        logic       uns;
        logic [1:0] size;
        logic [1:0] off;
        logic       err;
    } req_t;

    state_t      state;
    req_t        q;

    logic        req_err;
    logic [3:0]  req_strobe;
    logic [31:0] req_wdat;
    logic [31:0] rd_shift;
    logic [31:0] ld_dat;

    assign req_ready = (state == IDLE);

    // Request decode: error detection, byte strobes and lane-replicated store data.
    always_comb begin
        req_err = (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
               || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
        req_strobe = 4'b1111;
        req_wdat   = req_wdata;
        case (req_size)
            2'd0: begin
                req_strobe = 4'b0001 << req_addr[1:0];
                req_wdat   = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                req_strobe = 4'b0011 << req_addr[1:0];
                req_wdat   = {2{req_wdata[15:0]}};
            end
            default: begin
                req_strobe = 4'b1111;
                req_wdat   = req_wdata;
            end
        endcase
    end

    // Load alignment: move the addressed lane to bit 0, then extend.
    always_comb begin
        rd_shift = mem_rdata >> {q.off, 3'b000};
        case (q.size)
            2'd0:    ld_dat = q.uns ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_dat = q.uns ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_dat = rd_shift;
        endcase
    end

    // RAM controls are registered at accept so they are valid throughout ACCESS;
    // the async reset clears mem_wr_en at once, aborting a write mid-ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            q             <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= 32'd0;
            resp_err      <= 1'b0;
            mem_wr_en     <= 1'b0;
            mem_wr_strobe <= 4'b0000;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        q.we          <= req_we;
                        q.uns         <= req_unsigned;
                        q.size        <= req_size;
                        q.off         <= req_addr[1:0];
                        q.err         <= req_err;
                        mem_addr      <= req_addr[ADDR_WIDTH+1:2];
                        mem_wdata     <= req_wdat;
                        mem_wr_en     <= req_we && !req_err;
                        mem_wr_strobe <= (req_we && !req_err) ? req_strobe : 4'b0000;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_en     <= 1'b0;
                    mem_wr_strobe <= 4'b0000;
                    resp_valid    <= 1'b1;
                    resp_err      <= q.err;
                    resp_rdata    <= (q.we || q.err) ? 32'd0 : ld_dat;
                    state         <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the single-port, byte-strobed, combinational-read data RAM on behalf of the riscv32 core's memory stage.
- Accepts one core request via a valid/ready handshake, maps it to a word address, write strobe and lane-replicated write data, and performs the RAM access.
- Returns aligned, sign- or zero-extended load data, or an error, via a valid/ready response channel.
- Sits between core execute/memory stage and the data RAM.

Parameters:
- ADDR_WIDTH, 16, RAM word-address width; valid byte range is 0 .. (4<<ADDR_WIDTH)-1.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal-size request
- mem_wr_en  out  1  RAM write enable
- mem_wr_strobe  out  4  RAM byte strobes
- mem_addr  out  ADDR_WIDTH  RAM word address = byte address[ADDR_WIDTH+1:2]
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, mem_wr_en=0, mem_wr_strobe=0, mem_addr=0, mem_wdata=0.
- req_ready = (state==IDLE). It is 1 during and after reset.
- IDLE: when req_valid and req_ready are both high at cycle N, register the request, compute err, and go to ACCESS. Otherwise stay in IDLE.
- err is set when any of the following holds:
  - req_size==3
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - req_addr[31:ADDR_WIDTH+2] != 0
- ACCESS (cycle N+1):
  - mem_addr holds the registered word address.
  - mem_wr_en = we && !err.
  - mem_wr_strobe: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; forced to 0 when err or load.
  - mem_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Loads: at end of cycle, sample mem_rdata, shift right by 8*addr[1:0], then extend from bit 7 (byte) or bit 15 (half) per req_unsigned. Word loads are unmodified.
  - Always advance to RESP.
- RESP (cycle N+2 onward):
  - resp_valid=1; resp_rdata and resp_err are stable.
  - Hold until resp_ready=1. On that edge, clear resp_valid and return to IDLE.
  - Stores and errors return resp_rdata=0.
  - Minimum latency is 2 cycles from accept to resp_valid; throughput is 1 request per 3 cycles.
- Outside ACCESS, mem_wr_en=0 and mem_wr_strobe=0. mem_addr and mem_wdata hold their last values.
- Back-pressure:
  - req_valid asserted while not in IDLE is ignored; the request must be held until accepted.
  - resp_ready asserted outside RESP is ignored.
- Errored stores never modify RAM.
- Reset asserted during ACCESS clears mem_wr_en immediately, so no partial write occurs at the following edge. Reset in RESP drops resp_valid without a handshake.

Test Plan:
- Store word 0xDEADBEEF to 0x100, then load word from 0x100: strobe 1111, mem_addr=0x40; response 0xDEADBEEF, err=0, resp_valid at N+2.
- Store byte 0x80 to 0x103, then load byte signed and unsigned from 0x103: strobe 1000, mem_wdata=0x80808080; loads return 0xFFFFFF80 and 0x00000080; other bytes of the word are unchanged.
- Store half 0x8001 to 0x202, then load half signed from 0x202: strobe 1100; response 0xFFFF8001.
- Issue half store to 0x101, word load to 0x102, size=3 request, and address 0x00040000 (ADDR_WIDTH=16): all return err=1 and rdata=0; mem_wr_en never asserts; RAM contents unchanged.
- Load with resp_ready held low for 5 cycles while req_valid stays high: resp_valid and resp_rdata stay stable, req_ready=0, and the second request is accepted only in the cycle after the response handshake.
- Pulse rst while in ACCESS during a store: mem_wr_en drops immediately, the target word keeps its old value, and the FSM returns to IDLE with req_ready=1.
